call_scheduler: RTL and testbench

CALL_SCHEDULER -- requirements
Module: call_scheduler

---
 rtl/elevator_pkg.sv | 30 +++
 rtl/next_floor_sel.sv | 42 ++++
 rtl/call_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_call_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg -- shared types and constants for the elevator call scheduler.
//
//   NUM_FLOORS      : number of served floors (4)
//   floor_t         : 2-bit floor index
//   UP/DOWN/STOP    : car_state motion encodings reported by the controller
//   sched_state_t   : scheduler FSM states; DWELL exists only when the
//                     CALL_SCHED_DWELL_EN macro is defined
// ---------------------------------------------------------------------------
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;

    typedef logic [1:0] floor_t;

    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DOWN = 2'b10;
    localparam logic [1:0] STOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        SERVE_UP   = 2'b01,
        SERVE_DOWN = 2'b10
`ifdef CALL_SCHED_DWELL_EN
        ,
        DWELL      = 2'b11
`endif
    } sched_state_t;

endpackage

// File: rtl/next_floor_sel.sv
// ---------------------------------------------------------------------------
// next_floor_sel -- combinational search of the pending-call vector relative
// to the car position.
//
//   pending   [in]  outstanding calls, bit i = floor i
//   car_floor [in]  current car floor (3 bits; 4..7 lie above every floor)
//   dir       [in]  1 = lowest pending floor above car_floor,
//                   0 = highest pending floor below car_floor
//   found     [out] a matching floor exists
//   floor     [out] the matching floor (0 when found is 0)
// ---------------------------------------------------------------------------
module next_floor_sel
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [2:0]            car_floor,
    input  logic                  dir,
    output logic                  found,
    output floor_t                floor
);

    always_comb begin
        found = 1'b0;
        floor = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (dir) begin
                // Ascending scan: first hit is the nearest floor above.
                if (pending[i] && (3'(i) > car_floor) && !found) begin
                    found = 1'b1;
                    floor = floor_t'(i);
                end
            end else begin
                // Ascending scan: last hit is the nearest floor below.
                if (pending[i] && (3'(i) < car_floor)) begin
                    found = 1'b1;
                    floor = floor_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// ---------------------------------------------------------------------------
// call_scheduler -- SCAN-style hall-call scheduler feeding an elevator
// controller with a target floor.
//
// Parameters:
//   DWELL_CYCLES : door-open hold time in clk cycles at a served floor (1..255)
//
// Ports:
//   clk        [in]  clock, rising edge
//   reset      [in]  synchronous, active-high reset
//   call_btn   [in]  floor calls, bit i = floor i, level-sampled
//   car_floor  [in]  car floor from the controller (4..7 never match a floor)
//   car_state  [in]  controller motion state UP=01, DOWN=10, STOP=11
//   car_door   [in]  controller door flag, 1 = open
//   req_floor  [out] registered target floor
//   pending    [out] registered outstanding calls (call lamps)
//   dir_up     [out] registered sweep direction, 1 = up
//   busy       [out] registered, 1 when the FSM is not in IDLE
//
// Build option:
//   CALL_SCHED_DWELL_EN : compiles in the DWELL state and its timer. Without
//   it, arrival simply re-evaluates the sweep on the next cycle.
// ---------------------------------------------------------------------------
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [2:0]            car_floor,
    input  logic [1:0]            car_state,
    input  logic                  car_door,
    output logic [1:0]            req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy
);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_pend_nxt;
    logic [NUM_FLOORS-1:0] w_arrive;
    floor_t                r_req;
    floor_t                w_req_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic                  r_busy;
    floor_t                w_car_lo;

    logic                  w_up_found;
    floor_t                w_up_floor;
    logic                  w_dn_found;
    floor_t                w_dn_floor;

    // Sweep evaluation shared by every state that may pick a new target.
    logic                  w_pref_up;
    sched_state_t          w_sw_state;
    floor_t                w_sw_req;
    logic                  w_sw_dir;

`ifdef CALL_SCHED_DWELL_EN
    logic [7:0]            r_dwell_cnt;
    logic [7:0]            w_dwell_nxt;
    logic                  w_at_target;
`endif

    assign w_car_lo = car_floor[1:0];

    // Full 3-bit compare, so car_floor 4..7 never counts as arrival.
    always_comb begin
        w_arrive = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            w_arrive[i] = (car_state == STOP) && car_door && (car_floor == 3'(i));
        end
    end

    // Clear dominates a same-cycle call. Decisions use this next value so a
    // fresh call reaches req_floor with the same one-cycle latency as pending.
    assign w_pend_nxt = (r_pending | call_btn) & ~w_arrive;

    next_floor_sel u_sel_up (
        .pending   (w_pend_nxt),
        .car_floor (car_floor),
        .dir       (1'b1),
        .found     (w_up_found),
        .floor     (w_up_floor)
    );

    next_floor_sel u_sel_dn (
        .pending   (w_pend_nxt),
        .car_floor (car_floor),
        .dir       (1'b0),
        .found     (w_dn_found),
        .floor     (w_dn_floor)
    );

    // IDLE prefers up; a sweep keeps its own direction first; leaving DWELL
    // resumes the direction held in r_dir.
    always_comb begin
        w_pref_up = 1'b1;
        if (r_state == SERVE_DOWN) begin
            w_pref_up = 1'b0;
        end
`ifdef CALL_SCHED_DWELL_EN
        if (r_state == DWELL) begin
            w_pref_up = r_dir;
        end
`endif
    end

    always_comb begin
        w_sw_state = IDLE;
        w_sw_req   = w_car_lo;
        w_sw_dir   = r_dir;
        if (w_pref_up ? w_up_found : w_dn_found) begin
            w_sw_state = w_pref_up ? SERVE_UP : SERVE_DOWN;
            w_sw_req   = w_pref_up ? w_up_floor : w_dn_floor;
            w_sw_dir   = w_pref_up;
        end else if (w_pref_up ? w_dn_found : w_up_found) begin
            w_sw_state = w_pref_up ? SERVE_DOWN : SERVE_UP;
            w_sw_req   = w_pref_up ? w_dn_floor : w_up_floor;
            w_sw_dir   = !w_pref_up;
        end
    end

`ifdef CALL_SCHED_DWELL_EN
    assign w_at_target = w_arrive[r_req];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_dir_nxt   = r_dir;
`ifdef CALL_SCHED_DWELL_EN
        w_dwell_nxt = r_dwell_cnt;
`endif
        unique case (r_state)
            IDLE, SERVE_UP, SERVE_DOWN: begin
`ifdef CALL_SCHED_DWELL_EN
                if ((r_state != IDLE) && w_at_target) begin
                    w_state_nxt = DWELL;
                    w_req_nxt   = w_car_lo;
                    w_dwell_nxt = 8'(DWELL_CYCLES - 1);
                end else begin
                    w_state_nxt = w_sw_state;
                    w_req_nxt   = w_sw_req;
                    w_dir_nxt   = w_sw_dir;
                end
`else
                w_state_nxt = w_sw_state;
                w_req_nxt   = w_sw_req;
                w_dir_nxt   = w_sw_dir;
`endif
            end
`ifdef CALL_SCHED_DWELL_EN
            DWELL: begin
                // Exit is evaluated on the last dwell cycle so req_floor holds
                // the served floor for exactly DWELL_CYCLES cycles.
                if (r_dwell_cnt == 8'd0) begin
                    w_state_nxt = w_sw_state;
                    w_req_nxt   = w_sw_req;
                    w_dir_nxt   = w_sw_dir;
                end else begin
                    w_dwell_nxt = r_dwell_cnt - 8'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = w_car_lo;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_req     <= '0;
            r_dir     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_req     <= w_req_nxt;
            r_dir     <= w_dir_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

`ifdef CALL_SCHED_DWELL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell_cnt <= '0;
        end else begin
            r_dwell_cnt <= w_dwell_nxt;
        end
    end
`endif

    assign req_floor = r_req;
    assign pending   = r_pending;
    assign dir_up    = r_dir;
    assign busy      = r_busy;

endmodule

// File: tb/tb_call_scheduler.sv
// ---------------------------------------------------------------------------
// tb_call_scheduler -- self-checking bench for call_scheduler.
// Each stimulus row drives the inputs for one cycle and queues the outputs
// expected after the following rising edge; each scenario task pops and
// compares them. Dwell-dependent expectations follow CALL_SCHED_DWELL_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_call_scheduler;

    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_STOP = 2'b11;
    localparam int         DW     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] call_btn;
    logic [2:0] car_floor;
    logic [1:0] car_state;
    logic       car_door;
    logic [1:0] req_floor;
    logic [3:0] pending;
    logic       dir_up;
    logic       busy;

    typedef struct packed {
        logic [3:0] p;
        logic [1:0] r;
        logic       d;
        logic       b;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] call;
        logic [2:0] fl;
        logic [1:0] st;
        logic       door;
        exp_t       e;
    } row_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    call_scheduler #(.DWELL_CYCLES(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .call_btn  (call_btn),
        .car_floor (car_floor),
        .car_state (car_state),
        .car_door  (car_door),
        .req_floor (req_floor),
        .pending   (pending),
        .dir_up    (dir_up),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(input logic rst, input logic [3:0] call,
                                input logic [2:0] fl, input logic [1:0] st,
                                input logic door, input logic [3:0] p,
                                input logic [1:0] r, input logic d, input logic b);
        row_t x;
        x.rst = rst; x.call = call; x.fl = fl; x.st = st; x.door = door;
        x.e.p = p; x.e.r = r; x.e.d = d; x.e.b = b;
        return x;
    endfunction

    task automatic drive(input row_t x);
        reset     = x.rst;
        call_btn  = x.call;
        car_floor = x.fl;
        car_state = x.st;
        car_door  = x.door;
        sb.push_back(x.e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(mk(1, 4'b1111, 0, M_STOP, 1, 4'b0000, 0, 1, 0));
        rows.push_back(mk(1, 4'b1111, 0, M_STOP, 1, 4'b0000, 0, 1, 0));
        rows.push_back(mk(0, 4'b0000, 0, M_STOP, 1, 4'b0000, 0, 1, 0));
        foreach (rows[k]) begin
            drive(rows[k]); step();
            e = sb.pop_front(); o = {pending, req_floor, dir_up, busy};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset[%0d] got p=%b r=%0d d=%b b=%b want p=%b r=%0d d=%b b=%b",
                         k, o.p, o.r, o.d, o.b, e.p, e.r, e.d, e.b);
            end
        end
    endtask

    task automatic test_call_up();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(mk(0, 4'b1000, 0, M_STOP, 1, 4'b1000, 3, 1, 1));
        rows.push_back(mk(0, 4'b0000, 0, M_UP,   0, 4'b1000, 3, 1, 1));
        foreach (rows[k]) begin
            drive(rows[k]); step();
            e = sb.pop_front(); o = {pending, req_floor, dir_up, busy};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL call_up[%0d] got p=%b r=%0d d=%b b=%b want p=%b r=%0d d=%b b=%b",
                         k, o.p, o.r, o.d, o.b, e.p, e.r, e.d, e.b);
            end
        end
    endtask

    task automatic test_intercept();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(mk(0, 4'b0100, 1, M_UP, 0, 4'b1100, 2, 1, 1));
`ifdef CALL_SCHED_DWELL_EN
        for (int i = 0; i < DW; i++)
            rows.push_back(mk(0, 4'b0000, 2, M_STOP, 1, 4'b1000, 2, 1, 1));
`endif
        rows.push_back(mk(0, 4'b0000, 2, M_STOP, 1, 4'b1000, 3, 1, 1));
        foreach (rows[k]) begin
            drive(rows[k]); step();
            e = sb.pop_front(); o = {pending, req_floor, dir_up, busy};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL intercept[%0d] got p=%b r=%0d d=%b b=%b want p=%b r=%0d d=%b b=%b",
                         k, o.p, o.r, o.d, o.b, e.p, e.r, e.d, e.b);
            end
        end
    endtask

    task automatic test_switch_down();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(mk(0, 4'b0001, 2, M_UP, 0, 4'b1001, 3, 1, 1));
`ifdef CALL_SCHED_DWELL_EN
        for (int i = 0; i < DW; i++)
            rows.push_back(mk(0, 4'b0000, 3, M_STOP, 1, 4'b0001, 3, 1, 1));
`endif
        rows.push_back(mk(0, 4'b0000, 3, M_STOP, 1, 4'b0001, 0, 0, 1));
        foreach (rows[k]) begin
            drive(rows[k]); step();
            e = sb.pop_front(); o = {pending, req_floor, dir_up, busy};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL switch_down[%0d] got p=%b r=%0d d=%b b=%b want p=%b r=%0d d=%b b=%b",
                         k, o.p, o.r, o.d, o.b, e.p, e.r, e.d, e.b);
            end
        end
    endtask

    task automatic test_same_cycle_clear();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(mk(0, 4'b0000, 2, M_DOWN, 0, 4'b0001, 0, 0, 1));
        rows.push_back(mk(0, 4'b0010, 1, M_STOP, 1, 4'b0001, 0, 0, 1));
`ifdef CALL_SCHED_DWELL_EN
        for (int i = 0; i < DW; i++)
            rows.push_back(mk(0, 4'b0000, 0, M_STOP, 1, 4'b0000, 0, 0, 1));
`endif
        rows.push_back(mk(0, 4'b0000, 0, M_STOP, 1, 4'b0000, 0, 0, 0));
        foreach (rows[k]) begin
            drive(rows[k]); step();
            e = sb.pop_front(); o = {pending, req_floor, dir_up, busy};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL same_cycle_clear[%0d] got p=%b r=%0d d=%b b=%b want p=%b r=%0d d=%b b=%b",
                         k, o.p, o.r, o.d, o.b, e.p, e.r, e.d, e.b);
            end
        end
    endtask

    task automatic test_dwell();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(mk(0, 4'b1100, 0, M_STOP, 1, 4'b1100, 2, 1, 1));
        rows.push_back(mk(0, 4'b0000, 1, M_UP,   0, 4'b1100, 2, 1, 1));
`ifdef CALL_SCHED_DWELL_EN
        // Floor 2 served: req_floor held at 2 for DW cycles; a call landing
        // mid-dwell lights its lamp without moving the target.
        rows.push_back(mk(0, 4'b0000, 2, M_STOP, 1, 4'b1000, 2, 1, 1));
        for (int i = 1; i < DW; i++)
            rows.push_back(mk(0, (i == 2) ? 4'b0001 : 4'b0000, 2, M_STOP, 1,
                              (i >= 2) ? 4'b1001 : 4'b1000, 2, 1, 1));
        rows.push_back(mk(0, 4'b0000, 2, M_STOP, 1, 4'b1001, 3, 1, 1));
`else
        rows.push_back(mk(0, 4'b0000, 2, M_STOP, 1, 4'b1000, 3, 1, 1));
`endif
        foreach (rows[k]) begin
            drive(rows[k]); step();
            e = sb.pop_front(); o = {pending, req_floor, dir_up, busy};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL dwell[%0d] got p=%b r=%0d d=%b b=%b want p=%b r=%0d d=%b b=%b",
                         k, o.p, o.r, o.d, o.b, e.p, e.r, e.d, e.b);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(mk(1, 4'b0000, 0, M_STOP, 1, 4'b0000, 0, 1, 0));
        rows.push_back(mk(0, 4'b0110, 0, M_STOP, 1, 4'b0110, 1, 1, 1));
        rows.push_back(mk(0, 4'b0000, 0, M_UP,   0, 4'b0110, 1, 1, 1));
        rows.push_back(mk(1, 4'b1000, 0, M_UP,   0, 4'b0000, 0, 1, 0));
        rows.push_back(mk(0, 4'b0000, 0, M_STOP, 1, 4'b0000, 0, 1, 0));
        rows.push_back(mk(0, 4'b0010, 0, M_STOP, 1, 4'b0010, 1, 1, 1));
        // Out-of-range floor 5 aliases floor 1 in two bits; must not clear it.
        rows.push_back(mk(0, 4'b0000, 5, M_STOP, 1, 4'b0010, 1, 0, 1));
        rows.push_back(mk(0, 4'b0000, 5, M_STOP, 1, 4'b0010, 1, 0, 1));
        foreach (rows[k]) begin
            drive(rows[k]); step();
            e = sb.pop_front(); o = {pending, req_floor, dir_up, busy};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid[%0d] got p=%b r=%0d d=%b b=%b want p=%b r=%0d d=%b b=%b",
                         k, o.p, o.r, o.d, o.b, e.p, e.r, e.d, e.b);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        call_btn  = '0;
        car_floor = '0;
        car_state = M_STOP;
        car_door  = 1'b1;
        test_reset();
        test_call_up();
        test_intercept();
        test_switch_down();
        test_same_cycle_clear();
        test_dwell();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
